// File: rtl/instruction_loader_if.sv
// -----------------------------------------------------------------------------
// instruction_loader_if
// Bundles the loader's host-side byte stream handshake and its instruction-RAM
// write port / core-control outputs.
//
// Signals:
//   start                  single-cycle load request (host -> loader)
//   byte_in[7:0]           stream byte (host -> loader)
//   byte_valid             byte_in valid (host -> loader)
//   byte_ready             loader accepts a byte this cycle (loader -> host)
//   i_ram_input[31:0]      assembled instruction word (loader -> RAM)
//   i_ram_writing_address  RAM word address (loader -> RAM)
//   flag_write_i_ram       RAM write enable pulse (loader -> RAM)
//   cpu_hold               core stall (loader -> core)
//   load_done              load finished successfully (loader -> host)
//   load_error             framing error, bad word count (loader -> host)
//
// Modports: slave = loader side, master = host/bench side.
// -----------------------------------------------------------------------------
interface instruction_loader_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic [31:0]           i_ram_input;
   logic [ADDR_WIDTH-1:0] i_ram_writing_address;
   logic                  flag_write_i_ram;
   logic                  cpu_hold;
   logic                  load_done;
   logic                  load_error;

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, i_ram_input, i_ram_writing_address,
             flag_write_i_ram, cpu_hold, load_done, load_error
   );

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, i_ram_input, i_ram_writing_address,
             flag_write_i_ram, cpu_hold, load_done, load_error
   );
endinterface

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Fills the instruction RAM from a byte stream before the processor runs.
// The stream is a word count N (1..MAX_WORDS) followed by 4N bytes, each word
// sent MSB first. Every completed word is written to the RAM with a one-cycle
// write pulse at consecutive word addresses starting at 0. The core is held
// for the whole load and released once the last word has been written.
//
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous active-high reset, returns the loader to IDLE
//   io_bus  instruction_loader_if.slave: start / byte stream handshake in,
//           RAM write port, cpu_hold, load_done, load_error out
// -----------------------------------------------------------------------------
module instruction_loader #(
   parameter int MAX_WORDS  = 20,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   instruction_loader_if.slave   io_bus
);

   localparam int         CNT_W = $clog2(MAX_WORDS + 1);
   localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COUNT = 3'd1;
   localparam logic [2:0] S_BYTES = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   logic [2:0]            r_state;
   logic [CNT_W-1:0]      r_count;      // latched word count N
   logic [CNT_W-1:0]      r_idx;        // index of the word being assembled
   logic [1:0]            r_byte_cnt;   // bytes of the current word received
   logic [23:0]           r_shift;      // first three bytes of the current word
   logic [31:0]           r_data;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic w_ready;
   logic w_accept;
   logic w_count_ok;

   assign w_ready    = (r_state == S_COUNT) || (r_state == S_BYTES);
   assign w_accept   = w_ready && io_bus.byte_valid;
   assign w_count_ok = (io_bus.byte_in != 8'd0) && (io_bus.byte_in <= MAX_N);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_idx      <= '0;
         r_byte_cnt <= '0;
         r_data     <= '0;
         r_addr     <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (io_bus.start) begin
                  r_state <= S_COUNT;
               end
            end
            S_COUNT: begin
               if (w_accept) begin
                  if (w_count_ok) begin
                     r_count    <= io_bus.byte_in[CNT_W-1:0];
                     r_idx      <= '0;
                     r_byte_cnt <= '0;
                     r_state    <= S_BYTES;
                  end else begin
                     r_state <= S_ERROR;
                  end
               end
            end
            S_BYTES: begin
               if (w_accept) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  // The 4th byte completes the word: capture it straight into
                  // the RAM data/address registers so they stay stable outside
                  // the write cycle while the shift register keeps assembling.
                  if (r_byte_cnt == 2'd3) begin
                     r_data  <= {r_shift, io_bus.byte_in};
                     r_addr  <= ADDR_WIDTH'(r_idx);
                     r_state <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (r_idx == r_count - 1'b1) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_BYTES;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Assembly register carries no control meaning, so it is left unreset.
   always_ff @(posedge clock) begin
      if ((r_state == S_BYTES) && w_accept) begin
         r_shift <= {r_shift[15:0], io_bus.byte_in};
      end
   end

   assign io_bus.byte_ready            = w_ready;
   assign io_bus.flag_write_i_ram      = (r_state == S_WRITE);
   assign io_bus.i_ram_input           = r_data;
   assign io_bus.i_ram_writing_address = r_addr;
   // Core stays held on error so it never runs a partially loaded program.
   assign io_bus.cpu_hold              = (r_state == S_COUNT) || (r_state == S_BYTES) ||
                                         (r_state == S_WRITE) || (r_state == S_ERROR);
   assign io_bus.load_done             = (r_state == S_DONE);
   assign io_bus.load_error            = (r_state == S_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
// Directed bench for instruction_loader: a cycle-by-cycle vector table for the
// basic load / error / restart flow, followed by hand-written sequences for a
// full-depth load with upstream gaps and for reset during a load.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

   logic clock;
   logic reset;

   int n_checks = 0;
   int n_errors = 0;

   instruction_loader_if #(.ADDR_WIDTH(10)) bus ();

   instruction_loader #(
      .MAX_WORDS (20),
      .ADDR_WIDTH(10)
   ) dut (
      .clock (clock),
      .reset (reset),
      .io_bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        st;
      logic        vld;
      logic [7:0]  b;
      logic        rdy;
      logic        wr;
      logic [31:0] d;
      logic [9:0]  a;
      logic        hold;
      logic        done;
      logic        err;
   } vec_t;

   vec_t       tbl[25];
   logic [7:0]  stream[$];
   logic [31:0] exp_w[$];

   function automatic vec_t mk(input logic st, input logic vld, input logic [7:0] b,
                               input logic rdy, input logic wr, input logic [31:0] d,
                               input logic [9:0] a, input logic hold, input logic done,
                               input logic err);
      vec_t v;
      v.st = st; v.vld = vld; v.b = b; v.rdy = rdy; v.wr = wr;
      v.d = d; v.a = a; v.hold = hold; v.done = done; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic build_stream(input int n);
      logic [31:0] w;
      stream.delete();
      exp_w.delete();
      stream.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
         w = $urandom;
         stream.push_back(w[31:24]);
         stream.push_back(w[23:16]);
         stream.push_back(w[15:8]);
         stream.push_back(w[7:0]);
         exp_w.push_back(w);
      end
   endtask

   task automatic do_start();
      @(negedge clock); #1;
      bus.start = 1'b1;
      @(posedge clock); #1;
      bus.start = 1'b0;
   endtask

   // Streams the first nbytes of 'stream', checking every write pulse against
   // the expected word/address and that the core is held while loading.
   // Returns after the last byte (stop_at_end) or when the load terminates.
   task automatic feed(input int nbytes, input bit gaps, input bit stop_at_end,
                       input int budget, output int pulses);
      int ptr;
      int cyc;
      bit fin;
      ptr = 0; cyc = 0; pulses = 0; fin = 1'b0;
      while (!fin) begin
         @(negedge clock); #1;
         if (bus.flag_write_i_ram) begin
            chk("wr_addr", 32'(bus.i_ram_writing_address), 32'(pulses));
            if (pulses < exp_w.size())
               chk("wr_data", bus.i_ram_input, exp_w[pulses]);
            else
               chk("wr_extra_pulse", 32'(pulses), 32'(exp_w.size()));
            pulses++;
         end
         if (!bus.load_done && !bus.load_error)
            chk("hold_in_load", 32'(bus.cpu_hold), 32'd1);
         if (ptr >= nbytes && (stop_at_end || bus.load_done || bus.load_error)) begin
            bus.byte_valid = 1'b0;
            fin = 1'b1;
         end else if (cyc >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL feed_timeout: got %0d bytes accepted required %0d", ptr, nbytes);
            bus.byte_valid = 1'b0;
            fin = 1'b1;
         end else begin
            if (ptr < nbytes && (!gaps || $urandom_range(0, 2) != 0)) begin
               bus.byte_valid = 1'b1;
               bus.byte_in    = stream[ptr];
               if (bus.byte_ready) ptr++;
            end else begin
               bus.byte_valid = 1'b0;
            end
            cyc++;
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"},  32'(bus.byte_ready), 32'd0);
      chk({tag, "_wr"},   32'(bus.flag_write_i_ram), 32'd0);
      chk({tag, "_data"}, bus.i_ram_input, 32'd0);
      chk({tag, "_addr"}, 32'(bus.i_ram_writing_address), 32'd0);
      chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
      chk({tag, "_done"}, 32'(bus.load_done), 32'd0);
      chk({tag, "_err"},  32'(bus.load_error), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;

      tbl[0]  = mk(1, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 8'h02, 1, 0, 32'h0,        0, 1, 0, 0);
      tbl[2]  = mk(0, 1, 8'h68, 1, 0, 32'h0,        0, 1, 0, 0);
      tbl[3]  = mk(0, 1, 8'hA0, 1, 0, 32'h0,        0, 1, 0, 0);
      tbl[4]  = mk(0, 1, 8'h00, 1, 0, 32'h0,        0, 1, 0, 0);
      tbl[5]  = mk(0, 1, 8'h01, 1, 0, 32'h0,        0, 1, 0, 0);
      tbl[6]  = mk(0, 1, 8'h70, 0, 1, 32'h68A00001, 0, 1, 0, 0);
      tbl[7]  = mk(0, 1, 8'h70, 1, 0, 32'h68A00001, 0, 1, 0, 0);
      tbl[8]  = mk(0, 1, 8'h00, 1, 0, 32'h68A00001, 0, 1, 0, 0);
      tbl[9]  = mk(0, 1, 8'h00, 1, 0, 32'h68A00001, 0, 1, 0, 0);
      tbl[10] = mk(0, 1, 8'h00, 1, 0, 32'h68A00001, 0, 1, 0, 0);
      tbl[11] = mk(0, 0, 8'h00, 0, 1, 32'h70000000, 1, 1, 0, 0);
      tbl[12] = mk(0, 0, 8'h00, 0, 0, 32'h70000000, 1, 0, 1, 0);
      tbl[13] = mk(1, 0, 8'h00, 0, 0, 32'h70000000, 1, 0, 1, 0);
      tbl[14] = mk(0, 1, 8'h00, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[15] = mk(1, 0, 8'h00, 0, 0, 32'h70000000, 1, 1, 0, 1);
      tbl[16] = mk(0, 1, 8'h15, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[17] = mk(1, 0, 8'h00, 0, 0, 32'h70000000, 1, 1, 0, 1);
      tbl[18] = mk(0, 1, 8'h01, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[19] = mk(1, 1, 8'hDE, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[20] = mk(1, 1, 8'hAD, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[21] = mk(0, 1, 8'hBE, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[22] = mk(0, 1, 8'hEF, 1, 0, 32'h70000000, 1, 1, 0, 0);
      tbl[23] = mk(0, 0, 8'h00, 0, 1, 32'hDEADBEEF, 0, 1, 0, 0);
      tbl[24] = mk(0, 0, 8'h00, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0);

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      repeat (2) @(negedge clock);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b0;

      // Two-word load, count errors 0x00 / 0x15, restart with N=1.
      for (int i = 0; i < 25; i++) begin
         @(negedge clock); #1;
         bus.start      = tbl[i].st;
         bus.byte_valid = tbl[i].vld;
         bus.byte_in    = tbl[i].b;
         chk($sformatf("v%0d_rdy", i),  32'(bus.byte_ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_wr", i),   32'(bus.flag_write_i_ram), 32'(tbl[i].wr));
         chk($sformatf("v%0d_data", i), bus.i_ram_input, tbl[i].d);
         chk($sformatf("v%0d_addr", i), 32'(bus.i_ram_writing_address), 32'(tbl[i].a));
         chk($sformatf("v%0d_hold", i), 32'(bus.cpu_hold), 32'(tbl[i].hold));
         chk($sformatf("v%0d_done", i), 32'(bus.load_done), 32'(tbl[i].done));
         chk($sformatf("v%0d_err", i),  32'(bus.load_error), 32'(tbl[i].err));
      end
      bus.start      = 1'b0;
      bus.byte_valid = 1'b0;

      // Full-depth load with random upstream gaps.
      build_stream(20);
      do_start();
      feed(stream.size(), 1'b1, 1'b0, 2000, pulses);
      chk("full_pulses", 32'(pulses), 32'd20);
      chk("full_done",   32'(bus.load_done), 32'd1);
      chk("full_hold",   32'(bus.cpu_hold), 32'd0);
      chk("full_err",    32'(bus.load_error), 32'd0);

      // Reset after the 2nd byte of word 3 of an N=5 load.
      build_stream(5);
      do_start();
      feed(1 + 12 + 2, 1'b0, 1'b1, 200, pulses);
      chk("abort_pulses", 32'(pulses), 32'd3);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock); #1;
      chk_reset_outputs("abort");
      @(negedge clock); #1;
      chk("abort_idle_rdy", 32'(bus.byte_ready), 32'd0);
      chk("abort_idle_wr",  32'(bus.flag_write_i_ram), 32'd0);

      // Reset and start on the same edge during a load: reset wins.
      build_stream(5);
      do_start();
      feed(6, 1'b0, 1'b1, 200, pulses);
      chk("rs_pulses", 32'(pulses), 32'd1);
      reset     = 1'b1;
      bus.start = 1'b1;
      @(posedge clock); #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      @(negedge clock); #1;
      chk("rs_rdy",  32'(bus.byte_ready), 32'd0);
      chk("rs_hold", 32'(bus.cpu_hold), 32'd0);
      chk("rs_done", 32'(bus.load_done), 32'd0);
      @(negedge clock); #1;
      chk("rs_still_idle_rdy",  32'(bus.byte_ready), 32'd0);
      chk("rs_still_idle_hold", 32'(bus.cpu_hold), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader that sits directly upstream of the instruction RAM and fills it from a byte stream (host/UART side) before the processor runs. It drives the RAM's write port (data, write address, write flag), assembles 32-bit instruction words MSB-first, and holds the processor core while a load is in progress. Once a complete program has been written, it releases the core and reports completion or a framing error.

## Interface
- MAX_WORDS, 20, instruction RAM depth in words; the legal word count is 1..MAX_WORDS
- ADDR_WIDTH, 10, width of the RAM write address
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; one clock; when it is sampled high, the block returns to IDLE
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader accepts a byte this cycle; a byte transfers on an edge where valid and ready are both high
- i_ram_input  out  32  assembled instruction word, presented to the RAM write data input
- i_ram_writing_address  out  ADDR_WIDTH  RAM write address (word index)
- flag_write_i_ram  out  1  RAM write enable; one-cycle pulse per word
- cpu_hold  out  1  stalls the processor core while high
- load_done  out  1  level; high in DONE
- load_error  out  1  level; high in ERROR

## Operation
- Stream format:
  - The first byte is the word count N.
  - Then 4N bytes follow. The first byte of each word goes to bits 31:24 and the last to bits 7:0.
- IDLE:
  - byte_ready=0, cpu_hold=0, load_done=0, load_error=0.
  - start → COUNT.
- COUNT:
  - byte_ready=1, cpu_hold=1.
  - On accepting a byte with N in 1..MAX_WORDS: latch N, clear word index and byte counter → BYTES.
  - On accepting a byte with N=0 or N>MAX_WORDS → ERROR.
- BYTES:
  - byte_ready=1, cpu_hold=1.
  - Each accepted byte shifts into the assembly register (shift left 8, insert at 7:0) and increments a 2-bit byte counter.
  - Acceptance of the 4th byte → WRITE.
- WRITE (one cycle):
  - byte_ready=0, flag_write_i_ram=1.
  - i_ram_input = assembled word; i_ram_writing_address = word index.
  - If word index = N-1 → DONE. Otherwise increment the word index → BYTES.
- DONE:
  - load_done=1, cpu_hold=0, byte_ready=0.
  - start → COUNT, which clears load_done.
- ERROR:
  - load_error=1, cpu_hold=1, byte_ready=0; no RAM writes.
  - start → COUNT, which clears load_error.
- start in COUNT, BYTES or WRITE is ignored.
- Bytes offered while byte_ready=0 are not consumed; upstream must hold them.
- The word index never exceeds N-1, so the write address is always in 0..MAX_WORDS-1. Addresses are zero-extended to ADDR_WIDTH.
- i_ram_input and i_ram_writing_address hold their last values outside WRITE. They are only meaningful when flag_write_i_ram=1.

## Timing
- Reset values: state IDLE, byte_ready=0, flag_write_i_ram=0, i_ram_input=0, i_ram_writing_address=0, cpu_hold=0, load_done=0, load_error=0.
- Start latency: start sampled at edge k → COUNT from edge k+1, so byte_ready=1 in the cycle after the start cycle.
- Per-word cost with byte_valid held high: 4 accept cycles plus 1 WRITE cycle = 5 cycles.
- Write pulse: flag_write_i_ram is high in the cycle immediately after the 4th byte is accepted.
- Total load time with continuous valid: 1 count cycle + 5N cycles after entering COUNT.
- cpu_hold deassertion: cpu_hold falls in the cycle after the last WRITE, together with load_done rising.
- Reset mid-load: reset has priority over every other input. It aborts the load with no further writes; words already written stay in the RAM. The block is in IDLE next cycle with cpu_hold=0.
- Reset and start sampled high on the same edge: reset wins; the block stays IDLE.
- Upstream stalls (byte_valid low) may last any number of cycles in COUNT or BYTES; no timeout.

## Test plan
- Reset, then start, then stream 0x02, 0x68,0xA0,0x00,0x01, 0x70,0x00,0x00,0x00 with valid held high → two write pulses:
  - addr 0, data 0x68A00001;
  - addr 1, data 0x70000000;
  - load_done=1 and cpu_hold=0 exactly 11 cycles after COUNT entry.
- Full load of N=20 with random valid gaps → 20 pulses with addresses 0..19 in order and data matching the byte stream; cpu_hold high throughout the load.
- Count byte 0x00, then a separate run with count byte 0x15 → ERROR in each case, load_error=1, cpu_hold=1, no write pulses. A following start plus a valid N=1 stream loads correctly and clears load_error.
- Assert reset after the 2nd byte of word 3 in an N=5 load → exactly 3 write pulses (addr 0..2), then IDLE with all outputs at reset values. Repeat with reset and start high on the same edge → block stays IDLE.
- Pulse start during BYTES → ignored: word assembly and the address sequence are unchanged. A byte offered during WRITE is not consumed and is accepted in the following cycle.
